// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 core.
//   - CP0 register numbers as seen by mtc0/mfc0
//   - Status / Cause bit positions and the Status write mask
//   - ExcCode values
//   - cause_pack(): assembles the architectural Cause word from its fields
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

  // Only IM, EXL and IE may be changed by software.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP_HI  = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Cause layout: BD[31] TI[30] IP[15:8] ExcCode[6:2], everything else zero.
  function automatic logic [31:0] cause_pack(input logic       bd,
                                             input logic       ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exc);
    cause_pack = {bd, ti, 14'd0, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with prescaler.
//   clk, rst        : clock, synchronous active-high reset
//   count_we_i      : load Count from wdata_i, restart prescaler
//   compare_we_i    : load Compare from wdata_i, clear TI
//   wdata_i         : write data
//   count_o         : current Count
//   compare_o       : current Compare
//   ti_o            : timer interrupt, sticky until Compare is written
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    count_d   = count_q + {31'd0, tick};
    compare_d = compare_q;
    // Match is taken on the registered values, so TI lands one edge later.
    ti_d      = ti_q | (count_q == compare_q);
    if (count_we_i) begin
      count_d = wdata_i;
      presc_d = '0;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_timer_exc.sv
// cp0_timer_exc: coprocessor-0 core (BadVAddr, Count, Compare, Status,
// Cause, EPC) with timer interrupt, synchronised hardware interrupts,
// interrupt request generation and exception/ERET sequencing.
//   clk, rst            : clock, synchronous active-high reset
//   mtc0_we/waddr/wdata : register write port
//   raddr/rdata         : combinational read port (0 for unmapped numbers)
//   hw_int              : asynchronous hardware interrupt lines
//   exc_*               : exception commit (one-cycle exc_valid)
//   eret                : ERET commit
//   int_req             : interrupt pending and enabled
//   epc_out/status_out/cause_out : current register values
module cp0_timer_exc
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV       = 2,
  parameter int          INT_SYNC_STAGES = 2,
  parameter logic [31:0] RESET_STATUS    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0_we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic        exc_badvaddr_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);

  logic [INT_SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;

  logic [5:0]  hs;
  logic [7:0]  ip;
  logic [31:0] cause;
  logic [31:0] count, compare;
  logic        ti;
  logic        mtc0_ok;

  // exc_valid and eret both suppress any same-cycle mtc0, including timer writes.
  assign mtc0_ok = mtc0_we & ~exc_valid & ~eret;

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .count_we_i  (mtc0_ok && (waddr == CP0_COUNT)),
    .compare_we_i(mtc0_ok && (waddr == CP0_COMPARE)),
    .wdata_i     (wdata),
    .count_o     (count),
    .compare_o   (compare),
    .ti_o        (ti)
  );

  assign hs    = sync_q[INT_SYNC_STAGES-1];
  assign ip    = {hs[5] | ti, hs[4:0], ip_sw_q};
  assign cause = cause_pack(bd_q, ti, ip, exccode_q);

  assign int_req = status_q[ST_IE] & ~status_q[ST_EXL]
                 & (|(ip & status_q[ST_IM_HI:ST_IM_LO]));

  always_comb begin
    sync_d[0] = hw_int;
    for (int i = 1; i < INT_SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    status_d   = status_q;
    epc_d      = epc_q;
    exccode_d  = exccode_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    if (exc_valid) begin
      exccode_d        = exc_code;
      status_d[ST_EXL] = 1'b1;
      // A nested exception keeps the EPC/BD of the outermost one.
      if (!status_q[ST_EXL]) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end
      if (exc_badvaddr_we) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end else if (mtc0_we) begin
      case (waddr)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = wdata[9:8];
        CP0_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      badvaddr_q <= '0;
      status_q   <= RESET_STATUS;
      epc_q      <= '0;
      exccode_q  <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      badvaddr_q <= badvaddr_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      exccode_q  <= exccode_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign status_out = status_q;
  assign cause_out  = cause;

endmodule

// File: tb/tb_cp0_timer_exc.sv
// Bench for cp0_timer_exc: directed stimulus, a cycle-level model of the
// architectural registers checked every cycle, plus literal expectations.
module tb_cp0_timer_exc;

  localparam int DIV  = 2;
  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        mtc0_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic        exc_badvaddr_we;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;

  cp0_timer_exc #(
    .COUNT_DIV      (DIV),
    .INT_SYNC_STAGES(SYNC),
    .RESET_STATUS   (32'h0040_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mtc0_we        (mtc0_we),
    .waddr          (waddr),
    .wdata          (wdata),
    .raddr          (raddr),
    .rdata          (rdata),
    .hw_int         (hw_int),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_bd         (exc_bd),
    .exc_pc         (exc_pc),
    .exc_badvaddr_we(exc_badvaddr_we),
    .exc_badvaddr   (exc_badvaddr),
    .eret           (eret),
    .int_req        (int_req),
    .epc_out        (epc_out),
    .status_out     (status_out),
    .cause_out      (cause_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Count is kept as "value last loaded + elapsed cycles / DIV".
  logic        m_valid = 1'b0;
  int unsigned m_ticks;
  logic [31:0] m_base, m_compare, m_status, m_epc, m_bva;
  logic        m_ti, m_bd;
  logic [4:0]  m_exc;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hq[$];
  logic [31:0] m_c;
  logic        m_wr;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_ticks / DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [5:0] h;
    h = m_hq[0];
    return {h[5] | m_ti, h[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_intreq();
    return m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ticks = 0; m_base = 0; m_compare = 0; m_status = 32'h0040_0000;
      m_epc = 0; m_bva = 0; m_ti = 0; m_bd = 0; m_exc = 0; m_ipsw = 0;
      m_hq.delete();
      repeat (SYNC) m_hq.push_back(6'd0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_c  = m_count();
      m_wr = mtc0_we && !exc_valid && !eret;
      if (m_wr && waddr == 5'd11) m_ti = 1'b0;
      else if (m_c == m_compare)  m_ti = 1'b1;
      if (m_wr && waddr == 5'd9) begin
        m_base  = wdata;
        m_ticks = 0;
      end else begin
        m_ticks++;
      end
      if (m_wr && waddr == 5'd11) m_compare = wdata;
      m_hq.push_back(hw_int);
      void'(m_hq.pop_front());
      if (exc_valid) begin
        m_exc = exc_code;
        if (!m_status[1]) begin
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          m_bd  = exc_bd;
        end
        m_status[1] = 1'b1;
        if (exc_badvaddr_we) m_bva = exc_badvaddr;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (m_wr) begin
        if (waddr == 5'd12) m_status = {m_status[31:16], wdata[15:8], m_status[7:2], wdata[1:0]};
        if (waddr == 5'd13) m_ipsw = wdata[9:8];
        if (waddr == 5'd14) m_epc = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_int_req", {31'd0, int_req}, {31'd0, m_intreq()});
      check("cyc_status", status_out, m_status);
      check("cyc_cause", cause_out, m_cause());
      check("cyc_epc", epc_out, m_epc);
      check("cyc_rdata", rdata, m_rdata(raddr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; waddr = a; wdata = d;
    step(1);
    mtc0_we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic bwe, input logic [31:0] bva);
    exc_valid = 1'b1; exc_code = code; exc_bd = bd; exc_pc = pc;
    exc_badvaddr_we = bwe; exc_badvaddr = bva;
    step(1);
    exc_valid = 1'b0; exc_badvaddr_we = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; mtc0_we = 0; waddr = 0; wdata = 0; raddr = 0; hw_int = 0;
    exc_valid = 0; exc_code = 0; exc_bd = 0; exc_pc = 0;
    exc_badvaddr_we = 0; exc_badvaddr = 0; eret = 0;
    step(2);
    check("rst_status", status_out, 32'h0040_0000);
    check("rst_cause", cause_out, 32'd0);
    check("rst_epc", epc_out, 32'd0);
    check("rst_int_req", {31'd0, int_req}, 32'd0);
    rd(5'd9, 32'd0, "rst_count");
    rst = 1'b0;

    // 1: Count rate and wrap
    step(10);
    rd(5'd9, 32'd5, "count_after_10");
    wr(5'd9, 32'hFFFF_FFFE);
    rd(5'd9, 32'hFFFF_FFFE, "count_loaded");
    step(4);
    rd(5'd9, 32'd0, "count_wrap");

    // 2: timer interrupt
    wr(5'd11, 32'd3);
    check("ti_cleared_by_compare", {31'd0, cause_out[30]}, 32'd0);
    wr(5'd12, 32'h0000_8001);
    raddr = 5'd9;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (rdata == 32'd3) found = 1'b1;
      else step(1);
    end
    check("count_reaches_3", {31'd0, found}, 32'd1);
    check("ti_not_yet", {31'd0, cause_out[30]}, 32'd0);
    step(1);
    check("ti_set", {31'd0, cause_out[30]}, 32'd1);
    check("int_req_timer", {31'd0, int_req}, 32'd1);
    wr(5'd11, 32'd100);
    check("ti_clear", {31'd0, cause_out[30]}, 32'd0);
    check("int_req_drop", {31'd0, int_req}, 32'd0);

    // 3: exception in delay slot, then nested exception
    exc(5'd8, 1'b1, 32'h8000_0104, 1'b1, 32'hDEAD_BEEF);
    check("epc_bd", epc_out, 32'h8000_0100);
    check("cause_bd", {31'd0, cause_out[31]}, 32'd1);
    check("exccode_sys", {27'd0, cause_out[6:2]}, 32'd8);
    check("exl_set", {31'd0, status_out[1]}, 32'd1);
    check("int_req_exl", {31'd0, int_req}, 32'd0);
    rd(5'd8, 32'hDEAD_BEEF, "badvaddr");
    exc(5'd12, 1'b0, 32'h8000_0200, 1'b0, 32'd0);
    check("epc_nested", epc_out, 32'h8000_0100);
    check("bd_nested", {31'd0, cause_out[31]}, 32'd1);
    check("exccode_ov", {27'd0, cause_out[6:2]}, 32'd12);

    // 4: synchronised hardware interrupt, then exception/ERET
    wr(5'd12, 32'h0000_1001);
    check("status_im4", status_out, 32'h0040_1001);
    hw_int = 6'b000100;
    step(1);
    hw_int = 6'd0;
    check("ip4_stage1", {31'd0, cause_out[12]}, 32'd0);
    step(1);
    check("ip4_rise", {31'd0, cause_out[12]}, 32'd1);
    check("int_req_hw", {31'd0, int_req}, 32'd1);
    step(1);
    check("ip4_fall", {31'd0, cause_out[12]}, 32'd0);
    exc(5'd9, 1'b0, 32'h8000_0300, 1'b0, 32'd0);
    check("epc_no_bd", epc_out, 32'h8000_0300);
    check("bd_clear", {31'd0, cause_out[31]}, 32'd0);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("eret_exl", status_out, 32'h0040_1001);

    // 5: coinciding events, read-only and masked writes
    exc_valid = 1'b1; exc_code = 5'd10; exc_bd = 1'b0; exc_pc = 32'h8000_0400;
    eret = 1'b1; mtc0_we = 1'b1; waddr = 5'd12; wdata = 32'd0;
    step(1);
    exc_valid = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
    check("prio_status", status_out, 32'h0040_1003);
    check("prio_epc", epc_out, 32'h8000_0400);
    wr(5'd8, 32'h1234_5678);
    rd(5'd8, 32'hDEAD_BEEF, "badvaddr_ro");
    wr(5'd13, 32'hFFFF_FFFF);
    check("cause_sw_ip", cause_out & 32'h0000_037C, 32'h0000_0328);
    wr(5'd12, 32'hFFFF_FFFF);
    check("status_mask", status_out, 32'h0040_FF03);
    wr(5'd14, 32'hCAFE_F00D);
    check("epc_write", epc_out, 32'hCAFE_F00D);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("int_req_sw", {31'd0, int_req}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      raddr = 5'(a);
      step(1);
    end

    // 6: reset in the middle of operation
    wr(5'd11, 32'h0000_1234);
    wr(5'd9, 32'h0000_1234);
    step(1);
    check("pre_rst_ti", {31'd0, cause_out[30]}, 32'd1);
    rd(5'd9, 32'h0000_1234, "pre_rst_count");
    rst = 1'b1;
    step(1);
    check("mid_rst_status", status_out, 32'h0040_0000);
    check("mid_rst_cause", cause_out, 32'd0);
    check("mid_rst_epc", epc_out, 32'd0);
    check("mid_rst_int_req", {31'd0, int_req}, 32'd0);
    rd(5'd9, 32'd0, "mid_rst_count");
    rd(5'd11, 32'd0, "mid_rst_compare");
    rd(5'd8, 32'd0, "mid_rst_badvaddr");
    rst = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
